// File: rtl/dmem_model_pkg.sv
// Shared types and helpers for the dmem_model data-memory model.
package dmem_model_pkg;

  localparam int RD_LAT_MAX = 4;
  localparam int WORD_W     = 32;

  typedef struct packed {
    logic              valid;
    logic [WORD_W-1:0] data;
  } rd_stage_t;

  function automatic logic [7:0] byte_merge(input logic [7:0] old_byte,
                                            input logic [7:0] new_byte,
                                            input logic       en);
    return en ? new_byte : old_byte;
  endfunction

endpackage

// File: rtl/dmem_rd_pipe.sv
// RD_LAT-deep valid/data delay line; the last stage holds its data between reads.
module dmem_rd_pipe
  import dmem_model_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic      CLOCK,
  input  logic      RESET,
  input  rd_stage_t in_stage,
  output rd_stage_t out_stage
);

  if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
    $error("dmem_rd_pipe: RD_LAT out of range");
  end

  rd_stage_t stage    [RD_LAT];
  rd_stage_t shift_in [RD_LAT];

  always_comb begin
    shift_in[0] = in_stage;
    for (int i = 1; i < RD_LAT; i++) shift_in[i] = stage[i-1];
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < RD_LAT; i++) stage[i] <= '0;
    end else begin
      for (int i = 0; i < RD_LAT - 1; i++) stage[i] <= shift_in[i];
      stage[RD_LAT-1].valid <= shift_in[RD_LAT-1].valid;
      if (shift_in[RD_LAT-1].valid) stage[RD_LAT-1].data <= shift_in[RD_LAT-1].data;
    end
  end

  assign out_stage = stage[RD_LAT-1];

endmodule

// File: rtl/dmem_model.sv
// Synchronous data memory with pipelined read port, byte-masked write port and tohost exit watch.
// Optional bounds checking is enabled by defining DMEM_BOUNDS_CHECK_EN.
module dmem_model
  import dmem_model_pkg::*;
#(
  parameter int          DATA_W      = WORD_W,
  parameter int          ADDR_BITS   = 16,
  parameter int          DEPTH       = 65536,
  parameter int          RD_LAT      = 1,
  parameter int unsigned TOHOST_ADDR = 'hFFFF,
  parameter string       INIT_FILE   = ""
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [DATA_W-1:0]    rdata,
  output logic                 rvalid,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [DATA_W-1:0]    wdata,
  input  logic [DATA_W/8-1:0]  wbe,
  output logic                 tohost_valid,
  output logic [DATA_W-1:0]    tohost_data,
  output logic                 err
);

  localparam int NBYTES = DATA_W / 8;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (DATA_W != WORD_W) begin : g_bad_width
    $error("dmem_model: DATA_W must equal dmem_model_pkg::WORD_W");
  end

  logic [DATA_W-1:0] mem [DEPTH];

  // Zero-filled array at time 0.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  end

  logic [IDX_W-1:0]  ridx, widx;
  logic              rd_ok, wr_ok;
  logic [DATA_W-1:0] merged;
  logic              tohost_hit;
  rd_stage_t         in_stage, out_stage;

  assign ridx = IDX_W'(32'(raddr) % 32'(DEPTH));
  assign widx = IDX_W'(32'(waddr) % 32'(DEPTH));

`ifdef DMEM_BOUNDS_CHECK_EN
  assign rd_ok = 32'(raddr) < 32'(DEPTH);
  assign wr_ok = 32'(waddr) < 32'(DEPTH);

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) err <= 1'b0;
    else if ((re && !rd_ok) || (we && !wr_ok)) err <= 1'b1;
  end
`else
  assign rd_ok = 1'b1;
  assign wr_ok = 1'b1;
  assign err   = 1'b0;
`endif

  always_comb begin
    merged = mem[widx];
    for (int b = 0; b < NBYTES; b++)
      merged[8*b +: 8] = byte_merge(mem[widx][8*b +: 8], wdata[8*b +: 8], wbe[b]);
  end

  // NOTE: the array is deliberately left out of reset; only control state is cleared.
  // The non-blocking update also makes a same-edge read see the old word (read-first).
  always_ff @(posedge CLOCK) begin
    if (we && wr_ok && |wbe) mem[widx] <= merged;
  end

  assign tohost_hit = we && (32'(waddr) == TOHOST_ADDR) && |wbe;

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      tohost_valid <= 1'b0;
      tohost_data  <= '0;
    end else if (tohost_hit && !tohost_valid) begin
      tohost_valid <= 1'b1;
      tohost_data  <= merged;
    end
  end

  // Out-of-range reads still complete, returning zero.
  assign in_stage.valid = re;
  assign in_stage.data  = rd_ok ? mem[ridx] : '0;

  dmem_rd_pipe #(.RD_LAT(RD_LAT)) u_rd_pipe (
    .CLOCK     (CLOCK),
    .RESET     (RESET),
    .in_stage  (in_stage),
    .out_stage (out_stage)
  );

  assign rvalid = out_stage.valid;
  assign rdata  = out_stage.data;

endmodule

// File: tb/tb_dmem_model.sv
// Directed self-checking bench: three dmem_model instances (RD_LAT 1,2,3, DEPTH 1024) on shared inputs.
module tb_dmem_model;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b0;
  logic        re = 1'b0, we = 1'b0;
  logic [15:0] raddr = '0, waddr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wbe = '0;

  logic [31:0] rdata [3];
  logic        rvalid [3];
  logic        tohost_valid [3];
  logic [31:0] tohost_data [3];
  logic        err [3];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLOCK = ~CLOCK;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_model #(.RD_LAT(g + 1), .DEPTH(1024)) u_dut (
      .CLOCK        (CLOCK),
      .RESET        (RESET),
      .re           (re),
      .raddr        (raddr),
      .rdata        (rdata[g]),
      .rvalid       (rvalid[g]),
      .we           (we),
      .waddr        (waddr),
      .wdata        (wdata),
      .wbe          (wbe),
      .tohost_valid (tohost_valid[g]),
      .tohost_data  (tohost_data[g]),
      .err          (err[g])
    );
  end

  task automatic cycle();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic write_word(input logic [15:0] a, input logic [31:0] d, input logic [3:0] be);
    we = 1'b1; waddr = a; wdata = d; wbe = be;
    cycle();
    we = 1'b0; wbe = '0;
  endtask

  // After return, the RD_LAT=1 instance shows the result.
  task automatic read_lat1(input logic [15:0] a);
    re = 1'b1; raddr = a;
    cycle();
    re = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    cycle();
    cycle();
    for (int d = 0; d < 3; d++) begin
      n_cmp++; if (rvalid[d] !== 1'b0) begin n_bad++; $display("FAIL reset_rvalid[%0d]: got %b want 0", d, rvalid[d]); end
      n_cmp++; if (rdata[d] !== 32'h0) begin n_bad++; $display("FAIL reset_rdata[%0d]: got %h want 0", d, rdata[d]); end
      n_cmp++; if (tohost_valid[d] !== 1'b0) begin n_bad++; $display("FAIL reset_tohost_valid[%0d]: got %b want 0", d, tohost_valid[d]); end
      n_cmp++; if (tohost_data[d] !== 32'h0) begin n_bad++; $display("FAIL reset_tohost_data[%0d]: got %h want 0", d, tohost_data[d]); end
      n_cmp++; if (err[d] !== 1'b0) begin n_bad++; $display("FAIL reset_err[%0d]: got %b want 0", d, err[d]); end
    end
    RESET = 1'b1;
  endtask

  task automatic test_read_lat1();
    write_word(16'd5, 32'hDEADBEEF, 4'hF);
    n_cmp++; if (rvalid[0] !== 1'b0) begin n_bad++; $display("FAIL lat1_idle_rvalid: got %b want 0", rvalid[0]); end
    read_lat1(16'd5);
    n_cmp++; if (rvalid[0] !== 1'b1) begin n_bad++; $display("FAIL lat1_rvalid: got %b want 1", rvalid[0]); end
    n_cmp++; if (rdata[0] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL lat1_rdata: got %h want deadbeef", rdata[0]); end
    cycle();
    n_cmp++; if (rvalid[0] !== 1'b0) begin n_bad++; $display("FAIL lat1_rvalid_drop: got %b want 0", rvalid[0]); end
    n_cmp++; if (rdata[0] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL lat1_rdata_hold: got %h want deadbeef", rdata[0]); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_data [3];
    logic        exp_v;
    exp_data[0] = 32'h11; exp_data[1] = 32'h22; exp_data[2] = 32'h33;
    for (int i = 0; i < 3; i++) write_word(16'(i), exp_data[i], 4'hF);
    for (int k = 0; k < 6; k++) begin
      re = (k < 3); raddr = 16'(k);
      cycle();
      for (int d = 0; d < 3; d++) begin
        exp_v = (k >= d) && (k <= d + 2);
        n_cmp++; if (rvalid[d] !== exp_v) begin n_bad++; $display("FAIL b2b_rvalid lat%0d k%0d: got %b want %b", d + 1, k, rvalid[d], exp_v); end
        if (exp_v) begin
          n_cmp++; if (rdata[d] !== exp_data[k-d]) begin n_bad++; $display("FAIL b2b_rdata lat%0d k%0d: got %h want %h", d + 1, k, rdata[d], exp_data[k-d]); end
        end
      end
    end
    re = 1'b0;
  endtask

  task automatic test_byte_enables();
    write_word(16'd7, 32'hAABBCCDD, 4'hF);
    write_word(16'd7, 32'h11223344, 4'b0101);
    read_lat1(16'd7);
    n_cmp++; if (rdata[0] !== 32'hAA22CC44) begin n_bad++; $display("FAIL wbe_merge: got %h want aa22cc44", rdata[0]); end
    write_word(16'd7, 32'hFFFFFFFF, 4'b0000);
    read_lat1(16'd7);
    n_cmp++; if (rdata[0] !== 32'hAA22CC44) begin n_bad++; $display("FAIL wbe_zero_noop: got %h want aa22cc44", rdata[0]); end
  endtask

  task automatic test_read_write_same();
    write_word(16'd9, 32'h0, 4'hF);
    we = 1'b1; waddr = 16'd9; wdata = 32'h5; wbe = 4'hF;
    re = 1'b1; raddr = 16'd9;
    cycle();
    we = 1'b0; wbe = '0; re = 1'b0;
    n_cmp++; if (rvalid[0] !== 1'b1) begin n_bad++; $display("FAIL rw_same_rvalid: got %b want 1", rvalid[0]); end
    n_cmp++; if (rdata[0] !== 32'h0) begin n_bad++; $display("FAIL rw_same_old: got %h want 0", rdata[0]); end
    read_lat1(16'd9);
    n_cmp++; if (rdata[0] !== 32'h5) begin n_bad++; $display("FAIL rw_after_new: got %h want 5", rdata[0]); end
  endtask

  task automatic test_tohost();
    n_cmp++; if (tohost_valid[0] !== 1'b0) begin n_bad++; $display("FAIL tohost_pre_valid: got %b want 0", tohost_valid[0]); end
    write_word(16'hFFFF, 32'h1, 4'hF);
    n_cmp++; if (tohost_valid[0] !== 1'b1) begin n_bad++; $display("FAIL tohost_valid: got %b want 1", tohost_valid[0]); end
    n_cmp++; if (tohost_data[0] !== 32'h1) begin n_bad++; $display("FAIL tohost_data: got %h want 1", tohost_data[0]); end
    write_word(16'hFFFF, 32'h2, 4'hF);
    n_cmp++; if (tohost_valid[0] !== 1'b1) begin n_bad++; $display("FAIL tohost_valid_hold: got %b want 1", tohost_valid[0]); end
    n_cmp++; if (tohost_data[0] !== 32'h1) begin n_bad++; $display("FAIL tohost_data_first: got %h want 1", tohost_data[0]); end
  endtask

  task automatic test_reset_in_flight();
    re = 1'b1; raddr = 16'd5;
    cycle();
    re = 1'b0;
    RESET = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      n_cmp++; if (rvalid[d] !== 1'b0) begin n_bad++; $display("FAIL flight_rvalid[%0d]: got %b want 0", d, rvalid[d]); end
      n_cmp++; if (rdata[d] !== 32'h0) begin n_bad++; $display("FAIL flight_rdata[%0d]: got %h want 0", d, rdata[d]); end
    end
    n_cmp++; if (tohost_valid[0] !== 1'b0) begin n_bad++; $display("FAIL flight_tohost_valid: got %b want 0", tohost_valid[0]); end
    n_cmp++; if (tohost_data[0] !== 32'h0) begin n_bad++; $display("FAIL flight_tohost_data: got %h want 0", tohost_data[0]); end
    cycle();
    RESET = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      for (int d = 0; d < 3; d++) begin
        n_cmp++; if (rvalid[d] !== 1'b0) begin n_bad++; $display("FAIL flight_late_rvalid lat%0d k%0d: got %b want 0", d + 1, k, rvalid[d]); end
      end
    end
    read_lat1(16'd5);
    n_cmp++; if (rdata[0] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL flight_array_kept: got %h want deadbeef", rdata[0]); end
  endtask

`ifdef DMEM_BOUNDS_CHECK_EN
  task automatic test_bounds();
    n_cmp++; if (err[0] !== 1'b0) begin n_bad++; $display("FAIL bounds_err_pre: got %b want 0", err[0]); end
    write_word(16'd976, 32'h5A5A5A5A, 4'hF);
    write_word(16'd2000, 32'hFFFFFFFF, 4'hF);
    n_cmp++; if (err[0] !== 1'b1) begin n_bad++; $display("FAIL bounds_err: got %b want 1", err[0]); end
    read_lat1(16'd976);
    n_cmp++; if (rdata[0] !== 32'h5A5A5A5A) begin n_bad++; $display("FAIL bounds_suppressed: got %h want 5a5a5a5a", rdata[0]); end
    read_lat1(16'd2000);
    n_cmp++; if (rvalid[0] !== 1'b1) begin n_bad++; $display("FAIL bounds_rd_rvalid: got %b want 1", rvalid[0]); end
    n_cmp++; if (rdata[0] !== 32'h0) begin n_bad++; $display("FAIL bounds_rd_zero: got %h want 0", rdata[0]); end
  endtask
`else
  task automatic test_wrap();
    write_word(16'd1027, 32'h00000077, 4'hF);
    read_lat1(16'd3);
    n_cmp++; if (rdata[0] !== 32'h77) begin n_bad++; $display("FAIL wrap_alias: got %h want 77", rdata[0]); end
    n_cmp++; if (err[0] !== 1'b0) begin n_bad++; $display("FAIL wrap_err: got %b want 0", err[0]); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_read_lat1();
    test_back_to_back();
    test_byte_enables();
    test_read_write_same();
    test_tohost();
    test_reset_in_flight();
`ifdef DMEM_BOUNDS_CHECK_EN
    test_bounds();
`else
    test_wrap();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
